ahb_mux_nm1s: RTL and testbench

- Parametrised N-master to 1-slave AHB-Lite bus multiplexer with a registered arbiter.
- Selectable fixed-priority or round-robin arbitration.
- Keeps bursts unbroken and tracks address-phase and data-phase ownership separately, so HWDATA and HREADY follow the AHB pipeline across master switches.
- Sits between CPU/DMA masters and a single slave-side fabric port.

---
 rtl/ahb_mux_nm1s.sv | 128 ++++++++++++
 tb/tb_ahb_mux_nm1s.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mux_nm1s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_mux_nm1s : N-master to 1-slave AHB-Lite multiplexer, registered arbiter
//                with fixed-priority or round-robin selection.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ahb_mux_nm1s #(
  parameter int NM   = 4,
  parameter int DW   = 32,
  parameter int MODE = 1,
  localparam int MW  = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [NM*32-1:0]  HADDR_M,
  input  logic [NM*2-1:0]   HTRANS_M,
  input  logic [NM*3-1:0]   HBURST_M,
  input  logic [NM-1:0]     HWRITE_M,
  input  logic [NM*3-1:0]   HSIZE_M,
  input  logic [NM*DW-1:0]  HWDATA_M,
  output logic [NM-1:0]     HREADY_M,
  output logic [NM*DW-1:0]  HRDATA_M,
  input  logic              HREADY,
  input  logic [DW-1:0]     HRDATA,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [DW-1:0]     HWDATA,
  output logic [MW-1:0]     HMASTER
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [2:0] BURST_SINGLE = 3'b000;

  logic [31:0]   addr_a  [NM];
  logic [1:0]    trans_a [NM];
  logic [2:0]    burst_a [NM];
  logic [2:0]    size_a  [NM];
  logic [DW-1:0] wdata_a [NM];
  logic [NM-1:0] req;

  logic [MW-1:0] grant;
  logic [MW-1:0] downer;
  logic          dvalid;
  logic [MW-1:0] grant_nxt;
  logic          switch_ok;

  generate
    for (genvar i = 0; i < NM; i++) begin : g_unpack
      assign addr_a[i]  = HADDR_M[32*i +: 32];
      assign trans_a[i] = HTRANS_M[2*i +: 2];
      assign burst_a[i] = HBURST_M[3*i +: 3];
      assign size_a[i]  = HSIZE_M[3*i +: 3];
      assign wdata_a[i] = HWDATA_M[DW*i +: DW];
      assign req[i]     = HTRANS_M[2*i+1];
    end
  endgenerate

  assign HADDR    = addr_a[grant];
  assign HTRANS   = trans_a[grant];
  assign HBURST   = burst_a[grant];
  assign HWRITE   = HWRITE_M[grant];
  assign HSIZE    = size_a[grant];
  assign HWDATA   = wdata_a[downer];
  assign HMASTER  = grant;
  assign HRDATA_M = {NM{HRDATA}};

  // A switch is only safe when the grantee is idle or finishing a lone SINGLE.
  assign switch_ok = HREADY &&
                     ((trans_a[grant] == TRANS_IDLE) ||
                      ((trans_a[grant] == TRANS_NONSEQ) && (burst_a[grant] == BURST_SINGLE)));

  generate
    if (MODE == 0) begin : g_fixed
      always_comb begin
        grant_nxt = grant;
        if (switch_ok) begin
          for (int i = NM - 1; i >= 0; i--) begin
            if (req[i]) grant_nxt = MW'(i);
          end
        end
      end
    end else begin : g_rr
      logic found;
      // Scan starts after the grantee so it is considered last.
      always_comb begin
        grant_nxt = grant;
        found     = 1'b0;
        if (switch_ok) begin
          for (int k = 1; k <= NM; k++) begin
            if (!found && req[(int'(grant) + k) % NM]) begin
              grant_nxt = MW'((int'(grant) + k) % NM);
              found     = 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant  <= '0;
      downer <= '0;
      dvalid <= 1'b0;
    end else if (HREADY) begin
      grant  <= grant_nxt;
      downer <= grant;
      dvalid <= trans_a[grant][1];
    end
  end

  always_comb begin
    HREADY_M = '1;
    for (int i = 0; i < NM; i++) begin
      if ((MW'(i) == grant) || (dvalid && (MW'(i) == downer))) begin
        HREADY_M[i] = HREADY;
      end else if (req[i]) begin
        HREADY_M[i] = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mux_nm1s.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ahb_mux_nm1s : directed bench, one fixed-priority and one round-robin mux.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_ahb_mux_nm1s;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int MW = 2;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NSEQ   = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR4  = 3'b011;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [NM*32-1:0]  HADDR_M;
  logic [NM*2-1:0]   HTRANS_M;
  logic [NM*3-1:0]   HBURST_M;
  logic [NM-1:0]     HWRITE_M;
  logic [NM*3-1:0]   HSIZE_M;
  logic [NM*DW-1:0]  HWDATA_M;
  logic              HREADY;
  logic [DW-1:0]     HRDATA;

  logic [NM-1:0]     fp_hready_m, rr_hready_m;
  logic [NM*DW-1:0]  fp_hrdata_m, rr_hrdata_m;
  logic [31:0]       fp_haddr, rr_haddr;
  logic [1:0]        fp_htrans, rr_htrans;
  logic [2:0]        fp_hburst, rr_hburst;
  logic              fp_hwrite, rr_hwrite;
  logic [2:0]        fp_hsize, rr_hsize;
  logic [DW-1:0]     fp_hwdata, rr_hwdata;
  logic [MW-1:0]     fp_hmaster, rr_hmaster;

  int vectors = 0;
  int miscompares = 0;

  always #5 HCLK = ~HCLK;

  ahb_mux_nm1s #(.NM(NM), .DW(DW), .MODE(0)) u_fp (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M),
    .HBURST_M(HBURST_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADY_M(fp_hready_m), .HRDATA_M(fp_hrdata_m), .HREADY(HREADY), .HRDATA(HRDATA),
    .HADDR(fp_haddr), .HTRANS(fp_htrans), .HBURST(fp_hburst), .HWRITE(fp_hwrite),
    .HSIZE(fp_hsize), .HWDATA(fp_hwdata), .HMASTER(fp_hmaster)
  );

  ahb_mux_nm1s #(.NM(NM), .DW(DW), .MODE(1)) u_rr (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR_M(HADDR_M), .HTRANS_M(HTRANS_M),
    .HBURST_M(HBURST_M), .HWRITE_M(HWRITE_M), .HSIZE_M(HSIZE_M), .HWDATA_M(HWDATA_M),
    .HREADY_M(rr_hready_m), .HRDATA_M(rr_hrdata_m), .HREADY(HREADY), .HRDATA(HRDATA),
    .HADDR(rr_haddr), .HTRANS(rr_htrans), .HBURST(rr_hburst), .HWRITE(rr_hwrite),
    .HSIZE(rr_hsize), .HWDATA(rr_hwdata), .HMASTER(rr_hmaster)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_m(input int i, input logic [1:0] t, input logic [2:0] b,
                       input logic w, input logic [31:0] a);
    HTRANS_M[2*i +: 2]  = t;
    HBURST_M[3*i +: 3]  = b;
    HWRITE_M[i]         = w;
    HADDR_M[32*i +: 32] = a;
  endtask

  task automatic do_reset();
    HRESET   = 1'b1;
    HREADY   = 1'b1;
    HTRANS_M = '0;
    HBURST_M = '0;
    HWRITE_M = '0;
    tick();
    tick();
    HRESET = 1'b0;
  endtask

  int rr_exp [5] = '{1, 2, 3, 0, 1};

  initial begin
    HRESET   = 1'b1;
    HREADY   = 1'b1;
    HRDATA   = 32'hCAFE_F00D;
    HADDR_M  = '0;
    HTRANS_M = '0;
    HBURST_M = '0;
    HWRITE_M = '0;
    HSIZE_M  = {NM{3'b010}};
    for (int i = 0; i < NM; i++) HWDATA_M[DW*i +: DW] = 32'hA000_0000 + 32'(i);

    // reset state
    tick();
    tick();
    chk("rst_hmaster_fp", fp_hmaster, 0);
    chk("rst_hmaster_rr", rr_hmaster, 0);
    chk("rst_hready_m", fp_hready_m, 4'hF);
    chk("rst_htrans", fp_htrans, 2'b00);
    chk("rst_hwdata", fp_hwdata, 32'hA000_0000);
    chk("hrdata_copy0", fp_hrdata_m[31:0], 32'hCAFE_F00D);
    chk("hrdata_copy3", rr_hrdata_m[127:96], 32'hCAFE_F00D);

    // fixed priority: M1 and M2 request together
    HRESET = 1'b0;
    set_m(1, NSEQ, SINGLE, 1'b0, 32'h200);
    set_m(2, NSEQ, SINGLE, 1'b0, 32'h100);
    #1;
    chk("fp_a_hmaster", fp_hmaster, 0);
    chk("fp_a_hready_m", fp_hready_m, 4'b1001);
    tick();
    chk("fp_b_hmaster", fp_hmaster, 1);
    chk("fp_b_haddr", fp_haddr, 32'h200);
    chk("fp_b_hready_m", fp_hready_m, 4'b1011);
    chk("rr_b_hmaster", rr_hmaster, 1);
    tick();
    set_m(1, IDLE, SINGLE, 1'b0, 32'h0);
    #1;
    chk("fp_c_hmaster", fp_hmaster, 1);
    chk("rr_c_hmaster", rr_hmaster, 2);
    chk("rr_c_haddr", rr_haddr, 32'h100);
    tick();
    chk("fp_d_hmaster", fp_hmaster, 2);
    chk("fp_d_haddr", fp_haddr, 32'h100);

    // round robin: all four masters stream SINGLE NONSEQs
    do_reset();
    for (int i = 0; i < NM; i++) set_m(i, NSEQ, SINGLE, 1'b0, 32'h1000 * 32'(i + 1));
    #1;
    chk("rr_start_hmaster", rr_hmaster, 0);
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("rr_seq_hmaster", rr_hmaster, 64'(rr_exp[s]));
      chk("rr_seq_haddr", rr_haddr, 32'h1000 * 32'(rr_exp[s] + 1));
    end
    chk("fp_stream_hmaster", fp_hmaster, 0);

    // burst lock: M0 INCR4 while M1 waits
    do_reset();
    set_m(0, NSEQ, INCR4, 1'b0, 32'h40);
    set_m(1, NSEQ, SINGLE, 1'b0, 32'h80);
    #1;
    chk("burst_b0_hmaster", fp_hmaster, 0);
    chk("burst_b0_m1_ready", fp_hready_m[1], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      set_m(0, SEQ, INCR4, 1'b0, 32'h40 + 32'(4 * k));
      #1;
      chk("burst_fp_hmaster", fp_hmaster, 0);
      chk("burst_rr_hmaster", rr_hmaster, 0);
      chk("burst_haddr", fp_haddr, 32'h40 + 32'(4 * k));
      chk("burst_m1_ready", fp_hready_m[1], 1'b0);
    end
    tick();
    set_m(0, IDLE, SINGLE, 1'b0, 32'h0);
    #1;
    chk("burst_end_hmaster", fp_hmaster, 0);
    chk("burst_end_m1_ready", fp_hready_m[1], 1'b0);
    tick();
    chk("burst_sw_fp_hmaster", fp_hmaster, 1);
    chk("burst_sw_haddr", fp_haddr, 32'h80);
    chk("burst_sw_rr_hmaster", rr_hmaster, 1);

    // data-phase handoff with slave wait states
    do_reset();
    HWDATA_M[31:0]  = 32'hDEAD_BEEF;
    HWDATA_M[63:32] = 32'h1234_5678;
    set_m(0, NSEQ, SINGLE, 1'b1, 32'h10);
    set_m(1, NSEQ, SINGLE, 1'b0, 32'h20);
    #1;
    chk("ho_a_hmaster", rr_hmaster, 0);
    chk("ho_a_haddr", rr_haddr, 32'h10);
    tick();
    set_m(0, IDLE, SINGLE, 1'b0, 32'h0);
    HREADY = 1'b0;
    #1;
    chk("ho_b_hmaster", rr_hmaster, 1);
    chk("ho_b_haddr", rr_haddr, 32'h20);
    chk("ho_b_hwdata", rr_hwdata, 32'hDEAD_BEEF);
    chk("ho_b_hready_m", rr_hready_m[1:0], 2'b00);
    tick();
    chk("ho_c_hwdata", rr_hwdata, 32'hDEAD_BEEF);
    chk("ho_c_hmaster", rr_hmaster, 1);
    chk("ho_c_hready_m", rr_hready_m[1:0], 2'b00);
    HREADY = 1'b1;
    #1;
    chk("ho_c_hready_m_hi", rr_hready_m[1:0], 2'b11);
    chk("ho_c_hwdata_hi", rr_hwdata, 32'hDEAD_BEEF);
    tick();
    set_m(1, IDLE, SINGLE, 1'b0, 32'h0);
    #1;
    chk("ho_d_hwdata", rr_hwdata, 32'h1234_5678);

    // reset in the middle of an M3 burst
    do_reset();
    HWDATA_M[31:0]   = 32'hA0A0_A0A0;
    HWDATA_M[127:96] = 32'h3333_3333;
    set_m(3, NSEQ, INCR4, 1'b1, 32'h300);
    #1;
    tick();
    chk("mr_b_fp_hmaster", fp_hmaster, 3);
    chk("mr_b_rr_hmaster", rr_hmaster, 3);
    tick();
    set_m(3, SEQ, INCR4, 1'b1, 32'h304);
    #1;
    chk("mr_c_hwdata", fp_hwdata, 32'h3333_3333);
    chk("mr_c_hmaster", fp_hmaster, 3);
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    #1;
    chk("mr_d_hmaster", fp_hmaster, 0);
    chk("mr_d_hwdata", fp_hwdata, 32'hA0A0_A0A0);
    chk("mr_d_hready_m", fp_hready_m, 4'b0111);
    chk("mr_d_rr_hmaster", rr_hmaster, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
